vx_tcu_tfr_sf_sched: RTL and testbench

Step scheduler placed in front of the TCU TFR exponent/bias stage. Accepts one tile command (format, step count), then gates operand steps from the operand fetch path into the FEDP datapath. Each step carries fmtf, first/last flags and the matching MX scale-factor pair (sf_a, sf_b). Scale factors are buffered in a small FIFO and consumed once per MX block; MXFP8 steps stall when no scale factor is available.

---
 rtl/vx_tcu_tfr_sf_sched.sv | 201 ++++++++++++++++++++
 tb/tb_vx_tcu_tfr_sf_sched.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/vx_tcu_tfr_sf_sched.sv
// ---------------------------------------------------------------------------
// vx_tcu_tfr_sf_sched
// Step scheduler in front of the TCU TFR exponent/bias stage. Accepts one
// tile command, then gates operand steps from the operand fetch path into
// the FEDP datapath, tagging each step with its format, first/last flags and
// the MX block scale pair. Scale pairs are buffered in a small FIFO and one
// pair is consumed per MX block of BLK_STEPS steps (a short final block
// still consumes a pair). MXFP8 steps stall while the FIFO is empty.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   cmd_valid/cmd_ready   tile command handshake (cmd_fmtf, cmd_steps)
//   sf_valid_in/_ready_in scale pair push (sf_a_in, sf_b_in)
//   op_valid_in/ready_in  upstream operand step handshake
//   op_valid_out/ready_out datapath step handshake
//   fmtf, sf_a, sf_b      per-step format and scale pair
//   step_first, step_last step position flags
//   busy, done            activity and one-cycle completion pulse
//   sf_count              FIFO occupancy
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a tile command; scale outputs neutral (127)
// RUN   | passing operand steps through, popping scale pairs per block
// DONE  | one-cycle done pulse, then back to IDLE
// ---------------------------------------------------------------------------
module vx_tcu_tfr_sf_sched #(
    parameter int         DEPTH     = 4,
    parameter int         BLK_STEPS = 4,
    parameter int         STEP_W    = 8,
    parameter logic [2:0] MXFP8_ID  = 3'd5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      cmd_valid,
    input  logic [2:0]                cmd_fmtf,
    input  logic [STEP_W-1:0]         cmd_steps,
    output logic                      cmd_ready,
    input  logic                      sf_valid_in,
    input  logic [7:0]                sf_a_in,
    input  logic [7:0]                sf_b_in,
    output logic                      sf_ready_in,
    input  logic                      op_valid_in,
    output logic                      op_ready_in,
    output logic                      op_valid_out,
    input  logic                      op_ready_out,
    output logic [2:0]                fmtf,
    output logic [7:0]                sf_a,
    output logic [7:0]                sf_b,
    output logic                      step_first,
    output logic                      step_last,
    output logic                      busy,
    output logic                      done,
    output logic [$clog2(DEPTH):0]    sf_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int BLK_W = (BLK_STEPS > 1) ? $clog2(BLK_STEPS) : 1;

    localparam logic [STEP_W-1:0] STEP_ONE = STEP_W'(1);
    localparam logic [BLK_W-1:0]  BLK_ONE  = BLK_W'(1);
    localparam logic [BLK_W-1:0]  BLK_MAX  = BLK_W'(BLK_STEPS - 1);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [7:0]        SF_NEUTRAL = 8'd127;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         fmtf_q, fmtf_d;
    logic [STEP_W-1:0]  steps_q, steps_d;
    logic [STEP_W-1:0]  step_cnt_q, step_cnt_d;
    logic [BLK_W-1:0]   blk_cnt_q, blk_cnt_d;

    logic [7:0]         mem_a_q [DEPTH];
    logic [7:0]         mem_b_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic is_mx, sf_ok, in_run, fire, step_last_w, blk_last, push, pop;

    assign is_mx       = (fmtf_q == MXFP8_ID);
    assign sf_ok       = !is_mx || (cnt_q != '0);
    assign in_run      = (state_q == S_RUN);
    assign fire        = in_run && op_valid_in && op_ready_out && sf_ok;
    assign step_last_w = (step_cnt_q == (steps_q - STEP_ONE));
    assign blk_last    = (blk_cnt_q == BLK_MAX);

    // A full FIFO refuses the push even if a pop happens this cycle.
    assign sf_ready_in = (cnt_q != CNT_FULL);
    assign push        = sf_valid_in && sf_ready_in;
    // The last step of a tile closes a partial block, so it pops too.
    assign pop         = fire && is_mx && (blk_last || step_last_w);

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fmtf_q     <= '0;
            steps_q    <= '0;
            step_cnt_q <= '0;
            blk_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            fmtf_q     <= fmtf_d;
            steps_q    <= steps_d;
            step_cnt_q <= step_cnt_d;
            blk_cnt_q  <= blk_cnt_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        fmtf_d       = fmtf_q;
        steps_d      = steps_q;
        step_cnt_d   = step_cnt_q;
        blk_cnt_d    = blk_cnt_q;
        cmd_ready    = 1'b0;
        op_valid_out = 1'b0;
        op_ready_in  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    fmtf_d     = cmd_fmtf;
                    steps_d    = cmd_steps;
                    step_cnt_d = '0;
                    blk_cnt_d  = '0;
                    state_d    = (cmd_steps == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                // Scale-factor stalls are hidden from the datapath.
                op_valid_out = op_valid_in && sf_ok;
                op_ready_in  = op_ready_out && sf_ok;
                if (fire) begin
                    step_cnt_d = step_cnt_q + STEP_ONE;
                    blk_cnt_d  = blk_last ? '0 : (blk_cnt_q + BLK_ONE);
                    if (step_last_w) begin
                        blk_cnt_d = '0;
                        state_d   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ---------------- scale-factor FIFO ----------------
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a_q[wr_ptr_q] <= sf_a_in;
            mem_b_q[wr_ptr_q] <= sf_b_in;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q <= cnt_d;
        end
    end

    pop_on_empty: assert property (@(posedge clk) disable iff (reset) !(pop && (cnt_q == '0)));

    // ---------------- outputs ----------------
    assign fmtf       = fmtf_q;
    assign sf_a       = (state_q != S_IDLE && is_mx) ? mem_a_q[rd_ptr_q] : SF_NEUTRAL;
    assign sf_b       = (state_q != S_IDLE && is_mx) ? mem_b_q[rd_ptr_q] : SF_NEUTRAL;
    assign step_first = (step_cnt_q == '0);
    assign step_last  = step_last_w;
    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign sf_count   = cnt_q;

endmodule

// File: tb/tb_vx_tcu_tfr_sf_sched.sv
module tb_vx_tcu_tfr_sf_sched;

    localparam int DEPTH  = 4;
    localparam int BLK    = 4;
    localparam int STEP_W = 8;
    localparam logic [2:0] FP16 = 3'd1;
    localparam logic [2:0] BF16 = 3'd2;
    localparam logic [2:0] MX   = 3'd5;

    logic              clk = 1'b0;
    logic              reset;
    logic              cmd_valid;
    logic [2:0]        cmd_fmtf;
    logic [STEP_W-1:0] cmd_steps;
    logic              cmd_ready;
    logic              sf_valid_in;
    logic [7:0]        sf_a_in, sf_b_in;
    logic              sf_ready_in;
    logic              op_valid_in, op_ready_in, op_valid_out, op_ready_out;
    logic [2:0]        fmtf;
    logic [7:0]        sf_a, sf_b;
    logic              step_first, step_last, busy, done;
    logic [2:0]        sf_count;

    vx_tcu_tfr_sf_sched #(.DEPTH(DEPTH), .BLK_STEPS(BLK), .STEP_W(STEP_W), .MXFP8_ID(MX)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_fmtf(cmd_fmtf), .cmd_steps(cmd_steps), .cmd_ready(cmd_ready),
        .sf_valid_in(sf_valid_in), .sf_a_in(sf_a_in), .sf_b_in(sf_b_in), .sf_ready_in(sf_ready_in),
        .op_valid_in(op_valid_in), .op_ready_in(op_ready_in),
        .op_valid_out(op_valid_out), .op_ready_out(op_ready_out),
        .fmtf(fmtf), .sf_a(sf_a), .sf_b(sf_b),
        .step_first(step_first), .step_last(step_last),
        .busy(busy), .done(done), .sf_count(sf_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: tile phase (0 idle, 1 running, 2 done pulse),
    // steps completed so far, and a queue of buffered {a,b} pairs.
    int          m_mode;
    logic [2:0]  m_fmt;
    int          m_steps, m_k;
    logic [15:0] mq[$];

    // Observations of the DUT for directed checks.
    int cyc_n = 0;
    int n_fire = 0, n_done = 0, n_push = 0;
    int last_fire_cyc = -1, last_done_cyc = -1;
    logic [7:0] rec_a[$], rec_b[$];
    logic       rec_first[$], rec_last[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: check combinational outputs mid-cycle, then advance model.
    task automatic cyc();
        bit mx, ok, efire, epush, epop;
        logic [15:0] head;
        logic [31:0] e_a, e_b;
        #4;
        mx    = (m_fmt == MX);
        ok    = !mx || (mq.size() != 0);
        efire = (m_mode == 1) && op_valid_in && op_ready_out && ok;
        epush = sf_valid_in && (mq.size() != DEPTH);
        epop  = efire && mx && ((((m_k + 1) % BLK) == 0) || (m_k == m_steps - 1));

        chk("cmd_ready",    32'(cmd_ready),    32'(m_mode == 0));
        chk("busy",         32'(busy),         32'(m_mode != 0));
        chk("done",         32'(done),         32'(m_mode == 2));
        chk("op_valid_out", 32'(op_valid_out), 32'((m_mode == 1) && op_valid_in && ok));
        chk("op_ready_in",  32'(op_ready_in),  32'((m_mode == 1) && op_ready_out && ok));
        chk("sf_ready_in",  32'(sf_ready_in),  32'(mq.size() != DEPTH));
        chk("sf_count",     32'(sf_count),     32'(mq.size()));
        chk("fmtf",         32'(fmtf),         32'(m_fmt));
        if (m_mode == 1) begin
            chk("step_first", 32'(step_first), 32'(m_k == 0));
            chk("step_last",  32'(step_last),  32'(m_k == m_steps - 1));
        end
        if (m_mode == 0 || !mx || mq.size() != 0) begin
            if (m_mode == 0 || !mx) begin
                e_a = 127; e_b = 127;
            end else begin
                e_a = 32'(mq[0][15:8]); e_b = 32'(mq[0][7:0]);
            end
            chk("sf_a", 32'(sf_a), e_a);
            chk("sf_b", 32'(sf_b), e_b);
        end

        if (op_valid_out === 1'b1 && op_ready_out) begin
            n_fire++;
            last_fire_cyc = cyc_n;
            rec_a.push_back(sf_a);
            rec_b.push_back(sf_b);
            rec_first.push_back(step_first);
            rec_last.push_back(step_last);
        end
        if (done === 1'b1) begin
            n_done++;
            last_done_cyc = cyc_n;
        end
        if (sf_valid_in && sf_ready_in === 1'b1 && !reset) n_push++;

        @(posedge clk);
        if (reset) begin
            m_mode = 0;
            m_fmt  = '0;
            mq.delete();
        end else begin
            if (epop) head = mq.pop_front();
            if (epush) mq.push_back({sf_a_in, sf_b_in});
            case (m_mode)
                0: if (cmd_valid) begin
                    m_fmt   = cmd_fmtf;
                    m_steps = int'(cmd_steps);
                    m_k     = 0;
                    m_mode  = (cmd_steps == 0) ? 2 : 1;
                end
                1: if (efire) begin
                    m_k++;
                    if (m_k == m_steps) m_mode = 2;
                end
                default: m_mode = 0;
            endcase
        end
        cyc_n++;
        #1;
    endtask

    task automatic clear_rec();
        rec_a.delete(); rec_b.delete(); rec_first.delete(); rec_last.delete();
    endtask

    initial begin
        int nf0, nd0, np0, pc, ac, k;
        logic [7:0] ea [3];
        logic [7:0] eb [3];
        ea[0] = 8'd130; ea[1] = 8'd127; ea[2] = 8'd100;
        eb[0] = 8'd120; eb[1] = 8'd127; eb[2] = 8'd140;

        reset = 1'b1; cmd_valid = 0; cmd_fmtf = '0; cmd_steps = '0;
        sf_valid_in = 0; sf_a_in = '0; sf_b_in = '0; op_valid_in = 0; op_ready_out = 0;
        m_mode = 0; m_fmt = '0; m_steps = 0; m_k = 0;
        repeat (2) @(posedge clk);
        #1;
        cyc();
        reset = 1'b0;
        repeat (2) cyc();

        // FP16 tile of 3 steps with free-flowing handshakes
        clear_rec(); nf0 = n_fire; nd0 = n_done;
        cmd_valid = 1; cmd_fmtf = FP16; cmd_steps = 8'd3;
        cyc();
        cmd_valid = 0; op_valid_in = 1; op_ready_out = 1;
        for (int i = 0; i < 20 && n_done == nd0; i++) cyc();
        chk("fp16_fires", 32'(n_fire - nf0), 32'd3);
        chk("fp16_done_seen", 32'(n_done - nd0), 32'd1);
        chk("fp16_done_after_last", 32'(last_done_cyc), 32'(last_fire_cyc + 1));
        chk("fp16_first0", 32'(rec_first.size() > 0 ? rec_first[0] : 1'bx), 32'd1);
        chk("fp16_last0", 32'(rec_last.size() > 0 ? rec_last[0] : 1'bx), 32'd0);
        chk("fp16_last2", 32'(rec_last.size() > 2 ? rec_last[2] : 1'bx), 32'd1);
        chk("fp16_sf_a", 32'(rec_a.size() > 1 ? rec_a[1] : 8'hxx), 32'd127);
        op_valid_in = 0; op_ready_out = 0;
        cyc();

        // MXFP8 tile of 10 steps, three scale pairs pre-loaded
        sf_valid_in = 1;
        sf_a_in = 8'd130; sf_b_in = 8'd120; cyc();
        sf_a_in = 8'd127; sf_b_in = 8'd127; cyc();
        sf_a_in = 8'd100; sf_b_in = 8'd140; cyc();
        sf_valid_in = 0;
        clear_rec(); nd0 = n_done;
        cmd_valid = 1; cmd_fmtf = MX; cmd_steps = 8'd10;
        cyc();
        cmd_valid = 0; op_valid_in = 1; op_ready_out = 1;
        for (int i = 0; i < 30 && n_done == nd0; i++) cyc();
        chk("mx_fires", 32'(rec_a.size()), 32'd10);
        for (k = 0; k < 10; k++) begin
            chk("mx_step_sf_a", 32'(k < rec_a.size() ? rec_a[k] : 8'hxx), 32'(ea[k / BLK]));
            chk("mx_step_sf_b", 32'(k < rec_b.size() ? rec_b[k] : 8'hxx), 32'(eb[k / BLK]));
        end
        chk("mx_drained", 32'(sf_count), 32'd0);

        // MXFP8 stall on empty FIFO, then release by a push
        nf0 = n_fire;
        cmd_valid = 1; cmd_steps = 8'd1;
        cyc();
        cmd_valid = 0;
        repeat (5) cyc();
        chk("mx_stall_nofire", 32'(n_fire - nf0), 32'd0);
        sf_valid_in = 1; sf_a_in = 8'd128; sf_b_in = 8'd126;
        pc = cyc_n;
        cyc();
        sf_valid_in = 0;
        cyc();
        chk("fire_after_push", 32'(last_fire_cyc), 32'(pc + 1));
        chk("fire_after_push_sf_a", 32'(rec_a.size() > 0 ? rec_a[rec_a.size() - 1] : 8'hxx), 32'd128);
        op_valid_in = 0; op_ready_out = 0;
        repeat (2) cyc();

        // Fill beyond capacity; fifth pair waits for the first pop
        np0 = n_push;
        sf_valid_in = 1;
        for (int i = 0; i < 5; i++) begin
            sf_a_in = 8'(10 + i); sf_b_in = 8'(20 + i);
            cyc();
        end
        chk("fill_accepted", 32'(n_push - np0), 32'd4);
        nd0 = n_done;
        cmd_valid = 1; cmd_fmtf = MX; cmd_steps = 8'd4;
        cyc();
        cmd_valid = 0; op_valid_in = 1; op_ready_out = 1;
        for (int i = 0; i < 20 && n_done == nd0; i++) cyc();
        cyc();
        chk("fill_fifth_accepted", 32'(n_push - np0), 32'd5);
        sf_valid_in = 0;
        chk("fill_count", 32'(sf_count), 32'd4);

        // Reset in the middle of an MXFP8 tile
        nd0 = n_done;
        cmd_valid = 1; cmd_steps = 8'd8;
        cyc();
        cmd_valid = 0;
        repeat (2) cyc();
        reset = 1;
        cyc();
        reset = 0; op_valid_in = 0;
        repeat (3) cyc();
        chk("abort_no_done", 32'(n_done - nd0), 32'd0);
        chk("abort_count", 32'(sf_count), 32'd0);

        // Zero-step command goes straight to the done pulse
        nf0 = n_fire;
        op_valid_in = 1; op_ready_out = 1;
        cmd_valid = 1; cmd_fmtf = FP16; cmd_steps = 8'd0;
        ac = cyc_n;
        cyc();
        cmd_valid = 0;
        repeat (3) cyc();
        chk("zero_done_cycle", 32'(last_done_cyc), 32'(ac + 1));
        chk("zero_no_fire", 32'(n_fire - nf0), 32'd0);

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            reset        = ($urandom_range(0, 249) == 0);
            cmd_valid    = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 2))
                0: cmd_fmtf = FP16;
                1: cmd_fmtf = BF16;
                default: cmd_fmtf = MX;
            endcase
            cmd_steps    = 8'($urandom_range(0, 12));
            sf_valid_in  = ($urandom_range(0, 2) == 0);
            sf_a_in      = 8'($urandom);
            sf_b_in      = 8'($urandom);
            op_valid_in  = ($urandom_range(0, 3) != 0);
            op_ready_out = ($urandom_range(0, 3) != 0);
            cyc();
            if (rec_a.size() > 64) clear_rec();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
